rx_stack_loader: RTL

- Receive-side buffer between the photonic interconnect receiver and the general purpose register file's stack write port (register 0).
- Accepts inbound words from the network over a valid/ready handshake and holds them in a FIFO.
- On a pop request from the control unit, delivers the oldest word as a one-cycle stack write (stack_write_enable / stack_register_write_data).
- Signals a stall to the control unit when a pop is requested with nothing buffered.

---
 rtl/rx_stack_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rx_stack_loader.sv
// rx_stack_loader
//   Receive-side buffer between the photonic interconnect receiver and the
//   register file stack write port (register 0). Inbound words arrive over a
//   valid/ready handshake and are queued in a circular FIFO. A pop request
//   from the control unit delivers the oldest word one cycle later as a
//   single-cycle write strobe. A pop requested while nothing is buffered
//   raises a combinational stall instead.
//
// Ports
//   clk                        rising-edge clock
//   reset_n                    asynchronous active-low reset
//   rx_valid / rx_data         inbound word from the interconnect
//   rx_ready                   buffer can accept a word this cycle
//   pop_request                control unit wants the next word in register 0
//   flush                      synchronous clear of all buffered words
//   pop_stall                  pop requested while empty; control unit holds
//   stack_write_enable         one-cycle write strobe for register 0
//   stack_register_write_data  word written to register 0 (holds when idle)
//   word_count                 number of words currently buffered (0..depth)

module rx_stack_loader #(
  parameter int ADDR_WIDTH_FIFO = 3,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_valid,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  output logic                       rx_ready,
  input  logic                       pop_request,
  input  logic                       flush,
  output logic                       pop_stall,
  output logic                       stack_write_enable,
  output logic [DATA_WIDTH-1:0]      stack_register_write_data,
  output logic [ADDR_WIDTH_FIFO:0]   word_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH_FIFO;
  // Count value meaning "full": only the top bit of the count is set.
  localparam logic [ADDR_WIDTH_FIFO:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH_FIFO{1'b0}}};
  localparam logic [ADDR_WIDTH_FIFO-1:0] PTR_ONE = ADDR_WIDTH_FIFO'(1);
  localparam logic [ADDR_WIDTH_FIFO:0]   CNT_ONE = (ADDR_WIDTH_FIFO + 1)'(1);

  logic [DATA_WIDTH-1:0]      mem_r [DEPTH];
  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH_FIFO:0]   count_r;
  logic                       we_r;
  logic [DATA_WIDTH-1:0]      wdata_r;

  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [ADDR_WIDTH_FIFO:0]   count_nxt_s;
  logic                       we_nxt_s;
  logic [DATA_WIDTH-1:0]      wdata_nxt_s;

  logic full_s, empty_s, push_s, pop_s;

  // The count alone decides full/empty; pointers are free to wrap.
  assign full_s   = (count_r == DEPTH_CNT);
  assign empty_s  = (count_r == '0);
  // Ready ignores pop_request: a full buffer refuses even if a pop frees a slot.
  assign rx_ready = reset_n && !full_s;
  assign push_s   = rx_valid && rx_ready;
  assign pop_s    = pop_request && !empty_s;
  assign pop_stall = pop_request && empty_s;

  assign stack_write_enable        = we_r;
  assign stack_register_write_data = wdata_r;
  assign word_count                = count_r;

  // Next-state for pointers, count and the stack write port; flush wins.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    we_nxt_s     = 1'b0;
    wdata_nxt_s  = wdata_r;
    if (flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
      we_nxt_s     = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        we_nxt_s     = 1'b1;
        wdata_nxt_s  = mem_r[rd_ptr_r];
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
        we_nxt_s     = 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control and output registers; reset also cancels a strobe in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      we_r     <= 1'b0;
      wdata_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      we_r     <= we_nxt_s;
      wdata_r  <= wdata_nxt_s;
    end
  end

  // Storage array; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

endmodule
